// File: rtl/response_checker_if.sv
// Purpose: groups the stimulus handshake, observed response, control and statistics of response_checker.
// Latency: none, wires only.
// Backpressure: stim_ready from the checker gates stim_valid from the driver.
interface response_checker_if #(
    parameter int CW = 8
);
    logic          stim_valid;
    logic          stim_last;
    logic          A;
    logic          B;
    logic          F_obs;
    logic          clear;
    logic          stim_ready;
    logic          done;
    logic          pass;
    logic [CW-1:0] vec_count;
    logic [CW-1:0] err_count;
    logic [CW-1:0] glitch_count;

    // Stimulus side: drives vectors and observes results
    modport master (
        output stim_valid, stim_last, A, B, F_obs, clear,
        input  stim_ready, done, pass, vec_count, err_count, glitch_count
    );

    // Checker side
    modport slave (
        input  stim_valid, stim_last, A, B, F_obs, clear,
        output stim_ready, done, pass, vec_count, err_count, glitch_count
    );
endinterface

// File: rtl/response_checker.sv
// Purpose: applies A/B vectors to an XNOR-under-test, counts final-value mismatches and hazards on F_obs.
// Latency: counters update on the CHECK exit edge; one vector per SETTLE+2 cycles at best.
// Backpressure: stim_ready is high only in IDLE; stim_valid is ignored elsewhere, and clear beats stim_valid.
module response_checker #(
    parameter int SETTLE = 6,
    parameter int CW     = 8
) (
    input  logic               clock,
    input  logic               reset_L,
    response_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    state_t        state_q;
    state_t        state_d;
    logic          a_q;
    logic          b_q;
    logic          last_q;
    logic          prev_q;
    logic [1:0]    trans_q;
    logic [3:0]    settle_q;
    logic [CW-1:0] vec_q;
    logic [CW-1:0] err_q;
    logic [CW-1:0] glitch_q;
    logic          accept;
    logic          expected;

    // A vector is taken only from IDLE and never on a clear edge
    assign accept   = bus.stim_valid && (state_q == S_IDLE) && !bus.clear;
    // XNOR reference computed from the latched stimulus
    assign expected = ~(a_q ^ b_q);

    // State register
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_d        = state_q;
        bus.stim_ready = 1'b0;
        bus.done       = 1'b0;
        bus.pass       = 1'b0;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (bus.stim_valid) state_d = S_SETTLE;
                S_SETTLE: if (settle_q == 4'd0) state_d = S_CHECK;
                S_CHECK:  state_d = last_q ? S_DONE : S_IDLE;
                S_DONE:   state_d = S_DONE;
                default:  state_d = S_IDLE;
            endcase
        end
        case (state_q)
            S_IDLE: bus.stim_ready = 1'b1;
            S_DONE: begin
                bus.done = 1'b1;
                bus.pass = (err_q == '0);
            end
            default: ;
        endcase
    end

    // Vector capture and hazard tracking during the settle window
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            last_q   <= 1'b0;
            prev_q   <= 1'b0;
            trans_q  <= 2'd0;
            settle_q <= 4'd0;
        end else if (accept) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            last_q   <= bus.stim_last;
            prev_q   <= bus.F_obs;
            trans_q  <= 2'd0;
            settle_q <= SETTLE_LOAD;
        end else if (state_q == S_SETTLE && !bus.clear) begin
            if (bus.F_obs != prev_q && trans_q != 2'd3) begin
                trans_q <= trans_q + 2'd1;
            end
            prev_q <= bus.F_obs;
            if (settle_q != 4'd0) begin
                settle_q <= settle_q - 4'd1;
            end
        end
    end

    // Saturating statistics, updated as CHECK is left; clear wipes them and drops the vector
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            vec_q    <= '0;
            err_q    <= '0;
            glitch_q <= '0;
        end else if (bus.clear) begin
            vec_q    <= '0;
            err_q    <= '0;
            glitch_q <= '0;
        end else if (state_q == S_CHECK) begin
            if (vec_q != CNT_MAX) begin
                vec_q <= vec_q + CNT_ONE;
            end
            if (bus.F_obs != expected && err_q != CNT_MAX) begin
                err_q <= err_q + CNT_ONE;
            end
            if (trans_q >= 2'd2 && glitch_q != CNT_MAX) begin
                glitch_q <= glitch_q + CNT_ONE;
            end
        end
    end

    assign bus.vec_count    = vec_q;
    assign bus.err_count    = err_q;
    assign bus.glitch_count = glitch_q;

endmodule
